// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared digit widths, limits and the BCD time record type.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   localparam int DIGIT_W   = 4;
   localparam int MS_DIGITS = 3;
   localparam int MS_MAX    = 999;
   localparam int SEC_MAX   = 59;

   typedef struct packed {
      logic [7:0]  min;
      logic [7:0]  sec;
      logic [11:0] ms;
   } time_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One modulo-MOD BCD digit with increment-in / carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MOD = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);

   localparam logic [DIGIT_W-1:0] c_last = DIGIT_W'(MOD - 1);

   logic [DIGIT_W-1:0] r_q;
   logic               w_at_last;
   logic               w_illegal;

   assign w_at_last = (r_q == c_last);
   // Out-of-range codes self-heal to zero on the next edge
   assign w_illegal = (r_q > c_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr || w_illegal) begin
         r_q <= '0;
      end else if (inc) begin
         r_q <= w_at_last ? '0 : r_q + 1'b1;
      end
   end

   assign q     = r_q;
   assign carry = inc & w_at_last;

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : BCD mm:ss.mmm timekeeping datapath with lap freeze and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int   MIN_MAX       = 59,
   parameter logic LAP_RST_LEVEL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        time_en,
   input  logic        clr,
   input  logic        lap,
   output logic [11:0] ms_bcd,
   output logic [7:0]  sec_bcd,
   output logic [7:0]  min_bcd,
   output logic        wrap,
   output logic        lap_active
);

   localparam logic [7:0] c_min_max_bcd = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
   localparam int         c_sec_hi_mod  = SEC_MAX / 10 + 1;

   logic [MS_DIGITS:0] w_ms_carry;
   logic [3:0]         w_sec_lo;
   logic [3:0]         w_sec_hi;
   logic [3:0]         w_min_lo;
   logic [3:0]         w_min_hi;
   logic               w_sec_lo_carry;
   logic               w_sec_carry;
   logic               w_min_lo_carry;
   logic               w_unused_min_carry;
   logic               w_min_at_max;
   logic               w_min_illegal;
   logic               w_min_wrap;
   logic               w_min_clr;
   logic               w_lap_edge;
   time_t              w_live;
   time_t              w_disp;

   time_t              r_frozen;
   logic               r_lap_d;
   logic               r_lap_active;
   logic               r_wrap;

   assign w_ms_carry[0] = time_en;

   generate
      for (genvar gi = 0; gi < MS_DIGITS; gi++) begin : g_ms
         bcd_digit #(.MOD(10)) u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (w_ms_carry[gi]),
            .q     (w_live.ms[gi*DIGIT_W +: DIGIT_W]),
            .carry (w_ms_carry[gi+1])
         );
      end
   endgenerate

   bcd_digit #(.MOD(10)) u_sec_lo (
      .clk(clk), .rst(rst), .clr(clr), .inc(w_ms_carry[MS_DIGITS]),
      .q(w_sec_lo), .carry(w_sec_lo_carry)
   );

   bcd_digit #(.MOD(c_sec_hi_mod)) u_sec_hi (
      .clk(clk), .rst(rst), .clr(clr), .inc(w_sec_lo_carry),
      .q(w_sec_hi), .carry(w_sec_carry)
   );

   // Minutes roll over at MIN_MAX rather than at 99, so the pair is cleared
   // from here on the terminal count (or if it ever lands above the limit).
   assign w_min_at_max  = ({w_min_hi, w_min_lo} == c_min_max_bcd);
   assign w_min_illegal = ({w_min_hi, w_min_lo} > c_min_max_bcd);
   assign w_min_wrap    = w_sec_carry & w_min_at_max;
   assign w_min_clr     = clr | w_min_wrap | w_min_illegal;

   bcd_digit #(.MOD(10)) u_min_lo (
      .clk(clk), .rst(rst), .clr(w_min_clr), .inc(w_sec_carry),
      .q(w_min_lo), .carry(w_min_lo_carry)
   );

   bcd_digit #(.MOD(10)) u_min_hi (
      .clk(clk), .rst(rst), .clr(w_min_clr), .inc(w_min_lo_carry),
      .q(w_min_hi), .carry(w_unused_min_carry)
   );

   assign w_live.sec = {w_sec_hi, w_sec_lo};
   assign w_live.min = {w_min_hi, w_min_lo};

   assign w_lap_edge = lap & ~r_lap_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lap_d      <= LAP_RST_LEVEL;
         r_lap_active <= 1'b0;
         r_frozen     <= '0;
         r_wrap       <= 1'b0;
      end else begin
         r_lap_d <= lap;
         if (clr) begin
            r_lap_active <= 1'b0;
            r_frozen     <= '0;
            r_wrap       <= 1'b0;
         end else begin
            r_wrap <= w_min_wrap;
            if (w_lap_edge) begin
               if (!r_lap_active) begin
                  r_frozen <= w_live;
               end
               r_lap_active <= ~r_lap_active;
            end
         end
      end
   end

   assign w_disp     = r_lap_active ? r_frozen : w_live;
   assign ms_bcd     = w_disp.ms;
   assign sec_bcd    = w_disp.sec;
   assign min_bcd    = w_disp.min;
   assign wrap       = r_wrap;
   assign lap_active = r_lap_active;

endmodule
`default_nettype wire
